rv_muldiv_unit: RTL and testbench
=================================

Name: rv_muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the full RV32IM M-extension set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Parametrised in datapath width.
- Sits beside the ALU in the EX stage; the pipeline stalls on BUSY, in the same way it stalls on the memory busywait signals.
- FLUSH aborts an in-flight operation on a branch or jump squash.

Parameters:
- XLEN, 32, operand/result width in bits (≥8, power of 2).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE or DONE.
- FUNCT3  input  3  RISC-V M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND1  input  XLEN  rs1 value.
- OPERAND2  input  XLEN  rs2 value.
- FLUSH  input  1  abort current operation.
- RESULT  output  XLEN  result; valid while DONE=1, held until next accept.
- BUSY  output  1  operation in progress; the pipeline stalls EX.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, RESULT=0, BUSY=0, DONE=0, counter=0. Takes effect immediately, mid-operation included; no DONE is produced for the aborted operation.
- States: IDLE, CALC, FIN.
- IDLE/FIN with START=1 and FLUSH=0:
  - Latch FUNCT3 and operands; this is cycle 0.
  - Normal case: go to CALC.
  - Divide corner cases: go straight to FIN.
- FIN: DONE=1 and BUSY=0 for exactly one cycle. START in that cycle is accepted (back-to-back issue). Otherwise go to IDLE.
- CALC:
  - BUSY=1; one iteration per cycle; counter runs 0..XLEN-1.
  - After XLEN iterations, go to FIN.
  - Normal latency: DONE in cycle XLEN+1 after accept.
- START while BUSY=1: ignored; latched operands are unaffected.
- FLUSH=1:
  - In any state: next state IDLE, BUSY=0, no DONE pulse, RESULT unchanged.
  - FLUSH and START in the same cycle: FLUSH wins; the request is dropped.
- Multiply (radix-2 shift-add):
  - Convert operands to magnitudes according to signedness: MULH signed×signed; MULHSU signed×unsigned; MULHU and MUL unsigned×unsigned (the low half is sign-agnostic).
  - Form the 2·XLEN-bit product, then negate it if the result sign is negative.
  - MUL returns product[XLEN-1:0]; MULH* return product[2·XLEN-1:XLEN].
- Divide (restoring, unsigned core):
  - DIV/REM operate on magnitudes.
  - Quotient sign = sign(OPERAND1) XOR sign(OPERAND2).
  - Remainder sign = sign(OPERAND1).
  - Rounding is toward zero.
- Divide corner cases, resolved at accept with DONE in cycle 1:
  - Divisor = 0: DIV/DIVU return all-ones; REM/REMU return OPERAND1.
  - Signed overflow (OPERAND1 = most-negative value, OPERAND2 = −1): DIV returns OPERAND1; REM returns 0.
- Operands are sampled only at accept; input changes during CALC have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: all four multiply ops use a single combinational XLEN×XLEN multiplier. Accept goes directly to FIN, so DONE is asserted in cycle 1. Divides are unchanged.
- Undefined: multiplies use the iterative path, with DONE in cycle XLEN+1. No multiplier array is inferred.

Test Plan:
- Reset/idle: RESET=0 with START toggling → RESULT=0, BUSY=0, DONE=0 throughout. Release RESET → still idle until START.
- MUL 7×0xFFFFFFFD (XLEN=32) → BUSY cycles 1–32, DONE in cycle 33, RESULT=0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. With MULDIV_FAST_MUL_EN defined, the same values appear with DONE in cycle 1.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD in cycle 33. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases, DONE in cycle 1:
  - DIVU 100/0 → 0xFFFFFFFF.
  - REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Abort and reissue:
  - FLUSH in cycle 10 of a DIV → BUSY=0 in cycle 11, no DONE, RESULT keeps its previous value.
  - START+FLUSH in the same cycle → request dropped.
  - RESET=0 in cycle 15 → outputs are 0 immediately.
- Back-to-back and ignored START:
  - START asserted in the DONE cycle of a MUL → second op accepted, DONE 33 cycles later with the correct result.
  - START pulsed while BUSY → ignored, first result unchanged.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier; divides stay iterative.
module rv_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIN} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;

    // Accept-time decode: signedness, magnitudes and divide corner cases
    logic              s1, s2, a_neg, b_neg, div0, ovf, is_corner;
    logic [XLEN-1:0]   mag1, mag2, corner_res;

    always_comb begin
        s2         = (FUNCT3 == 3'b001) | (FUNCT3[2] & ~FUNCT3[0]);
        s1         = s2 | (FUNCT3 == 3'b010);
        a_neg      = s1 & OPERAND1[XLEN-1];
        b_neg      = s2 & OPERAND2[XLEN-1];
        mag1       = a_neg ? -OPERAND1 : OPERAND1;
        mag2       = b_neg ? -OPERAND2 : OPERAND2;
        div0       = (OPERAND2 == '0);
        ovf        = ~FUNCT3[0] & (OPERAND1 == MIN_VAL) & (&OPERAND2);
        is_corner  = FUNCT3[2] & (div0 | ovf);
        if (div0) begin
            corner_res = FUNCT3[1] ? OPERAND1 : '1;
        end else begin
            corner_res = FUNCT3[1] ? '0 : OPERAND1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fp;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fa       = {{XLEN{a_neg}}, OPERAND1};
        fb       = {{XLEN{b_neg}}, OPERAND2};
        fp       = fa * fb;
        fast_res = (FUNCT3[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`endif

    // One iteration: {hi,lo} shift-add for multiply, shift-subtract for divide
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [XLEN-1:0]   step_hi, step_lo;

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, m_q};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = shifted[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[XLEN:1];
            step_lo = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection after the last iteration
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   q_s, r_s, calc_res;

    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -step_lo : step_lo;
        r_s    = neg_q ? -step_hi : step_hi;
        if (op_q[2]) begin
            calc_res = op_q[1] ? r_s : q_s;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (START) begin
                    op_d  = FUNCT3;
                    hi_d  = '0;
                    cnt_d = '0;
                    if (FUNCT3[2]) begin
                        m_d   = mag2;
                        lo_d  = mag1;
                        neg_d = FUNCT3[1] ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        m_d   = mag1;
                        lo_d  = mag2;
                        neg_d = a_neg ^ b_neg;
                    end
                    if (is_corner) begin
                        state_d  = ST_FIN;
                        done_d   = 1'b1;
                        result_d = corner_res;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!FUNCT3[2]) begin
                        state_d  = ST_FIN;
                        done_d   = 1'b1;
                        result_d = fast_res;
`endif
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                hi_d   = step_hi;
                lo_d   = step_lo;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = ST_FIN;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = calc_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Squash wins over everything, including a same-cycle request
        if (FLUSH) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: stimulus pushes expected results, a monitor checks every DONE.
module tb_rv_muldiv_unit;

    localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MUL_LAT = 1;
`else
    localparam int unsigned MUL_LAT = XLEN + 1;
`endif
    localparam int unsigned DIV_LAT = XLEN + 1;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            START = 1'b0;
    logic            FLUSH = 1'b0;
    logic [2:0]      FUNCT3 = '0;
    logic [XLEN-1:0] OPERAND1 = '0;
    logic [XLEN-1:0] OPERAND2 = '0;
    logic [XLEN-1:0] RESULT;
    logic            BUSY;
    logic            DONE;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [XLEN-1:0] res;
        int unsigned     cyc;
        string           name;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation in value and cycle
    always @(negedge CLK) begin
        exp_t e;
        if (RESET && DONE) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: DONE at cycle %0d with RESULT %h, expected no DONE", cyc, RESULT);
            end else begin
                e = sb.pop_front();
                if (RESULT !== e.res || cyc != e.cyc || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL %s: got RESULT %h cycle %0d BUSY %b, expected RESULT %h cycle %0d BUSY 0",
                             e.name, RESULT, cyc, BUSY, e.res, e.cyc);
                end
            end
        end
    end

    // Call at posedge+1; the current cycle is cycle 0 of the request
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] res, input int unsigned lat, input bit expect_done,
                         input string name);
        exp_t e;
        FUNCT3   = f;
        OPERAND1 = a;
        OPERAND2 = b;
        START    = 1'b1;
        if (expect_done) begin
            e.res  = res;
            e.cyc  = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        START    = 1'b0;
        OPERAND1 = $urandom;
        OPERAND2 = $urandom;
        FUNCT3   = 3'($urandom);
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge CLK);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] res, input int unsigned lat, input string name);
        issue(f, a, b, res, lat, 1'b1, name);
        drain(XLEN + 20, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with START toggling: nothing may happen
        for (int i = 0; i < 4; i++) begin
            START = i[0]; FUNCT3 = F_DIVU; OPERAND1 = 32'd100; OPERAND2 = '0;
            @(posedge CLK); #1;
            check("rst_result", RESULT, '0);
            check("rst_busy", XLEN'(BUSY), '0);
            check("rst_done", XLEN'(DONE), '0);
        end
        START = 1'b0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("idle_busy", XLEN'(BUSY), '0);
        check("idle_result", RESULT, '0);

        // MUL with BUSY profile
        issue(F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 1'b1, "mul_7xm3");
        @(negedge CLK);
`ifdef MULDIV_FAST_MUL_EN
        check("mul_busy_c1", XLEN'(BUSY), '0);
`else
        check("mul_busy_c1", XLEN'(BUSY), XLEN'(1));
        repeat (31) @(negedge CLK);
        check("mul_busy_c32", XLEN'(BUSY), XLEN'(1));
        check("mul_done_c32", XLEN'(DONE), '0);
`endif
        drain(XLEN + 20, "mul_7xm3");

        run(F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh_min_min");
        run(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu_max_max");
        run(F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, "mulhsu_m1_2");
        run(F_MULH,   32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, MUL_LAT, "mulh_m1_7");
        run(F_MULHU,  32'hFFFFFFFF, 32'd7,        32'h00000006, MUL_LAT, "mulhu_max_7");
        run(F_MUL,    32'h12345678, 32'h10,       32'h23456780, MUL_LAT, "mul_shift");
        run(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_m7_2");
        run(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "rem_m7_2");
        run(F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, "div_7_m2");
        run(F_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT, "rem_7_m2");
        run(F_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT, "divu_big");
        run(F_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT, "divu_by1");
        run(F_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, DIV_LAT, "remu_16");
        run(F_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1, "divu_by0");
        run(F_REMU,   32'd100,      32'd0,        32'd100,      1, "remu_by0");
        run(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");
        run(F_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, "div_m7_by0");
        run(F_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, "rem_m7_by0");
        run(F_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, "remu_100_7");
        run(F_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, "divu_100_7");

        // FLUSH in cycle 10 of a DIV: no DONE, RESULT keeps 14
        issue(F_DIV, 32'hFFFFFFF9, 32'd2, '0, 0, 1'b0, "flush_div");
        repeat (9) @(posedge CLK);
        #1;
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        check("flush_busy", XLEN'(BUSY), '0);
        check("flush_done", XLEN'(DONE), '0);
        check("flush_result", RESULT, 32'd14);
        repeat (40) @(posedge CLK);
        #1;

        // START and FLUSH together: request dropped
        FUNCT3 = F_DIVU; OPERAND1 = 32'd100; OPERAND2 = '0;
        START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        @(negedge CLK);
        check("startflush_busy", XLEN'(BUSY), '0);
        check("startflush_result", RESULT, 32'd14);
        repeat (5) @(posedge CLK);
        #1;

        // Asynchronous reset in cycle 15 of a DIV
        issue(F_DIV, 32'hFFFFFFF9, 32'd2, '0, 0, 1'b0, "reset_div");
        repeat (14) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midrst_result", RESULT, '0);
        check("midrst_busy", XLEN'(BUSY), '0);
        check("midrst_done", XLEN'(DONE), '0);
        @(posedge CLK); #3;
        RESET = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        check("postrst_busy", XLEN'(BUSY), '0);

        // Back-to-back: second MUL accepted in the DONE cycle of the first
        issue(F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 1'b1, "b2b_mul1");
        repeat (MUL_LAT - 1) @(posedge CLK);
        #1;
        issue(F_MULH, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1'b1, "b2b_mul2");
        drain(2 * XLEN + 20, "b2b");

        // START while BUSY is ignored
        issue(F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1, "busy_divu");
        repeat (3) @(posedge CLK);
        #1;
        FUNCT3 = F_REMU; OPERAND1 = 32'd1000; OPERAND2 = 32'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        drain(XLEN + 20, "busy_divu");
        repeat (5) @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
